// File: rtl/sub_8_bit_serial_pkg.sv
// Shared constants and state encoding for the bit-serial 8-bit subtractor.
package sub_8_bit_serial_pkg;

  localparam int SUB_W = 8;
  localparam int CNT_W = $clog2(SUB_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SUB_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_NEG   = 2'd2,
    S_DONE  = 2'd3
  } state_e;

endpackage

// File: rtl/sub_8_bit_serial_if.sv
// Operand/result bundle of the serial subtractor with requester (master) and
// subtractor (slave) views.
interface sub_8_bit_serial_if
  import sub_8_bit_serial_pkg::*;
();

  // Start is sampled only while idle; Busy covers the whole operation including
  // the Done cycle; Done is a one-cycle pulse after which D/Bout/Neg hold.
  logic             Start;
  logic [SUB_W-1:0] A;
  logic [SUB_W-1:0] B;
  logic [SUB_W-1:0] D;
  logic             Bout;
  logic             Neg;
  logic             Busy;
  logic             Done;

  modport master (output Start, A, B, input D, Bout, Neg, Busy, Done);
  modport slave  (input Start, A, B, output D, Bout, Neg, Busy, Done);

endinterface

// File: rtl/sub_8_bit_serial_fs.sv
// 1-bit full subtractor: d = a - b - bin, with borrow out.
module sub_8_bit_serial_fs (
  input  logic a_i,
  input  logic b_i,
  input  logic bin_i,
  output logic d_o,
  output logic bout_o
);

  assign d_o    = a_i ^ b_i ^ bin_i;
  assign bout_o = (~a_i & b_i) | (~(a_i ^ b_i) & bin_i);

endmodule

// File: rtl/sub_8_bit_serial.sv
// Bit-serial 8-bit subtractor, LSB first, one bit per cycle.
// Define SUB_ABS_EN to report the magnitude |A-B| with a Neg flag.
module sub_8_bit_serial
  import sub_8_bit_serial_pkg::*;
(
  input  logic                      Clk,
  input  logic                      Rst,
  sub_8_bit_serial_if.slave         bus,
  output state_e                    dbg_state_o
);

  state_e           state_q, state_d;
  logic [SUB_W-1:0] a_q, a_d, b_q, b_d, r_q, r_d, d_q, d_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             bw_q, bw_d, bout_q, bout_d;
  logic             fs_a, fs_b, fs_bin, fs_d, fs_bout;

  // Negation reuses the subtractor as 0 - r, which equals invert-plus-one.
`ifdef SUB_ABS_EN
  logic neg_q, neg_d;
  assign fs_a = (state_q == S_NEG) ? 1'b0 : a_q[0];
  assign fs_b = (state_q == S_NEG) ? r_q[0] : b_q[0];
`else
  assign fs_a = a_q[0];
  assign fs_b = b_q[0];
`endif
  assign fs_bin = bw_q;

  sub_8_bit_serial_fs u_fs (
    .a_i    (fs_a),
    .b_i    (fs_b),
    .bin_i  (fs_bin),
    .d_o    (fs_d),
    .bout_o (fs_bout)
  );

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    r_d     = r_q;
    bw_d    = bw_q;
    cnt_d   = cnt_q;
    d_d     = d_q;
    bout_d  = bout_q;
`ifdef SUB_ABS_EN
    neg_d   = neg_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        if (bus.Start) begin
          a_d     = bus.A;
          b_d     = bus.B;
          bw_d    = 1'b0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        a_d   = a_q >> 1;
        b_d   = b_q >> 1;
        r_d   = {fs_d, r_q[SUB_W-1:1]};
        bw_d  = fs_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
`ifdef SUB_ABS_EN
          if (fs_bout) begin
            state_d = S_NEG;
            cnt_d   = '0;
            bw_d    = 1'b0;
          end else
`endif
          begin
            state_d = S_DONE;
            d_d     = {fs_d, r_q[SUB_W-1:1]};
            bout_d  = fs_bout;
`ifdef SUB_ABS_EN
            neg_d   = 1'b0;
`endif
          end
        end
      end
`ifdef SUB_ABS_EN
      S_NEG: begin
        r_d   = {fs_d, r_q[SUB_W-1:1]};
        bw_d  = fs_bout;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_MAX) begin
          state_d = S_DONE;
          d_d     = {fs_d, r_q[SUB_W-1:1]};
          bout_d  = 1'b1;
          neg_d   = 1'b1;
        end
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      r_q     <= '0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      d_q     <= '0;
      bout_q  <= 1'b0;
`ifdef SUB_ABS_EN
      neg_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      r_q     <= r_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      d_q     <= d_d;
      bout_q  <= bout_d;
`ifdef SUB_ABS_EN
      neg_q   <= neg_d;
`endif
    end
  end

  assign bus.D       = d_q;
  assign bus.Bout    = bout_q;
`ifdef SUB_ABS_EN
  assign bus.Neg     = neg_q;
`else
  assign bus.Neg     = 1'b0;
`endif
  assign bus.Busy    = (state_q != S_IDLE);
  assign bus.Done    = (state_q == S_DONE);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sub_8_bit_serial.sv
// Self-checking bench for sub_8_bit_serial: arithmetic/latency model, directed
// pins and randomized traffic (honours SUB_ABS_EN like the design).
module tb_sub_8_bit_serial;
  import sub_8_bit_serial_pkg::*;

  // ---------------- clock / reset ----------------
  logic   clk = 1'b0;
  logic   rst;
  state_e dbg_state;
  always #5 clk = ~clk;

  sub_8_bit_serial_if bus ();

  sub_8_bit_serial dut (
    .Clk         (clk),
    .Rst         (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

`ifdef SUB_ABS_EN
  localparam bit ABS = 1'b1;
`else
  localparam bit ABS = 1'b0;
`endif

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted operation's result {neg,bout,d} is computed arithmetically and
  // queued; it becomes visible once the operation's latency has elapsed.
  logic [9:0]  exp_q[$];
  int          m_phase = 0;   // 0 idle, 1 computing, 2 done cycle
  int          m_rem   = 0;
  logic [7:0]  m_d     = '0;
  logic        m_bout  = 1'b0;
  logic        m_neg   = 1'b0;

  always @(posedge clk) begin
    logic [7:0] diff;
    logic       bo, ng;
    if (rst) begin
      m_phase = 0;
      m_d     = '0;
      m_bout  = 1'b0;
      m_neg   = 1'b0;
      exp_q.delete();
    end else begin
      case (m_phase)
        0: if (bus.Start === 1'b1) begin
          bo   = (bus.A < bus.B);
          diff = bus.A - bus.B;
          ng   = 1'b0;
          if (ABS && bo) begin
            diff = bus.B - bus.A;
            ng   = 1'b1;
          end
          m_rem   = (ABS && bo) ? 16 : 8;
          exp_q.push_back({ng, bo, diff});
          m_phase = 1;
        end
        1: begin
          m_rem--;
          if (m_rem == 0) begin
            {m_neg, m_bout, m_d} = exp_q.pop_front();
            m_phase = 2;
          end
        end
        default: m_phase = 0;
      endcase
    end
  end

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      check("busy", 32'(bus.Busy), 32'(m_phase != 0));
      check("done", 32'(bus.Done), 32'(m_phase == 2));
      check("d",    32'(bus.D),    32'(m_d));
      check("bout", 32'(bus.Bout), 32'(m_bout));
      check("neg",  32'(bus.Neg),  32'(m_neg));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic run_op(input logic [7:0] a, input logic [7:0] b, input bit poke,
                        output int lat, output logic [9:0] res);
    @(negedge clk);
    bus.Start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) begin
        lat = k;
        break;
      end
      bus.Start = 1'b0;
      bus.A     = 8'($urandom);
      bus.B     = 8'($urandom);
      if (poke && k == 3) begin
        bus.Start = 1'b1;
        bus.A     = 8'hFF;
        bus.B     = 8'h01;
      end
    end
    bus.Start = 1'b0;
    res = {bus.Neg, bus.Bout, bus.D};
  endtask

  function automatic logic [7:0] pick_operand();
    case ($urandom_range(0, 5))
      0:       return 8'h00;
      1:       return 8'hFF;
      2:       return 8'h80;
      default: return 8'($urandom);
    endcase
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    int         lat, pulses, last_k, ndone;
    logic [9:0] res;

    rst = 1'b1; bus.Start = 1'b0; bus.A = '0; bus.B = '0;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    check("rst_outputs", {bus.Busy, bus.Done, bus.Neg, bus.Bout, bus.D}, 32'h0);
    rst = 1'b0;

    // 0x50-0x20 with an ignored Start poke mid-operation
    run_op(8'h50, 8'h20, 1'b1, lat, res);
    check("p50_20_res", res, {2'b00, 8'h30});
    check("p50_20_lat", lat, 9);

    run_op(8'h20, 8'h50, 1'b0, lat, res);
    check("p20_50_res", res, ABS ? {2'b11, 8'h30} : {2'b01, 8'hD0});
    check("p20_50_lat", lat, ABS ? 17 : 9);

    // reset during SHIFT aborts the operation without a Done
    @(negedge clk); bus.Start = 1'b1; bus.A = 8'h50; bus.B = 8'h20;
    @(negedge clk); bus.Start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_outputs", {bus.Busy, bus.Done, bus.Neg, bus.Bout, bus.D}, 32'h0);
    rst = 1'b0;
    ndone = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.Done === 1'b1) ndone++;
    end
    check("abort_no_done", ndone, 0);

    run_op(8'h50, 8'h20, 1'b0, lat, res);
    check("post_abort_res", res, {2'b00, 8'h30});
    check("post_abort_lat", lat, 9);

    run_op(8'h00, 8'hFF, 1'b0, lat, res);
    check("p00_ff_res", res, ABS ? {2'b11, 8'hFF} : {2'b01, 8'h01});

    run_op(8'h00, 8'h00, 1'b0, lat, res);
    check("p00_00_res", res, {2'b00, 8'h00});
    check("p00_00_lat", lat, 9);

    // Start held high: one result every 10 cycles
    @(negedge clk); bus.Start = 1'b1; bus.A = 8'h07; bus.B = 8'h03;
    pulses = 0; last_k = 0;
    for (int k = 1; k <= 45; k++) begin
      @(negedge clk);
      if (bus.Done === 1'b1) begin
        check("b2b_d", 32'(bus.D), 32'h04);
        if (pulses > 0) check("b2b_period", k - last_k, 10);
        else            check("b2b_first", k, 9);
        pulses++;
        last_k = k;
      end
    end
    check("b2b_pulses", pulses, 4);
    bus.Start = 1'b0;
    repeat (20) @(negedge clk);

    // randomized traffic with occasional resets
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      bus.Start = ($urandom_range(0, 3) == 0);
      bus.A     = pick_operand();
      bus.B     = pick_operand();
      rst       = ($urandom_range(0, 99) == 0);
    end
    @(negedge clk);
    bus.Start = 1'b0;
    rst       = 1'b0;
    repeat (25) @(negedge clk);
    check("drain_idle", 32'(bus.Busy), 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
